// File: rtl/mag_pkg.sv
// rtl/mag_pkg.sv - shared types and defaults for the magnetron cook sequencer
// Contents:
//   mag_state_t   : cook-cycle state (IDLE, COOKING, PAUSED, DONE)
//   TICK_DIV_DEF  : default clock cycles per one-second tick
//   TIME_W_DEF    : default width of the seconds countdown
package mag_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COOKING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } mag_state_t;

  localparam int TICK_DIV_DEF = 100_000_000;
  localparam int TIME_W_DEF   = 12;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - one-second tick prescaler for the cook countdown
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the count this cycle
//   clr        : zero the count (overrides en)
//   tick       : high when the count sits at TICK_DIV-1 and en is high
module tick_prescaler
  import mag_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  // With en low the count simply holds, which is what lets a paused
  // cook resume mid-second without losing or gaining cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/mag_controller.sv
// rtl/mag_controller.sv - magnetron cook-cycle sequencer driving the latch S/R inputs
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load/time_in : write cook time (seconds) into the countdown
//   start        : begin or resume cooking
//   clear        : abort and zero the countdown
//   door_closed  : synchronised door switch, 1 = closed
//   S, R         : one-cycle latch set / reset pulses (never both high)
//   mag_on       : high while cooking
//   remaining    : current countdown value
//   done         : one-cycle pulse when the countdown expires
module mag_controller
  import mag_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int TIME_W   = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [TIME_W-1:0] time_in,
  input  logic              start,
  input  logic              clear,
  input  logic              door_closed,
  output logic              S,
  output logic              R,
  output logic              mag_on,
  output logic [TIME_W-1:0] remaining,
  output logic              done
);

  mag_state_t        state, state_nx;
  logic [TIME_W-1:0] rem_nx;
  logic              s_nx, r_nx, done_nx;
  logic              pre_en, pre_clr, tick;

  // The prescaler only advances while genuinely cooking this cycle; a
  // door-open or clear edge must not consume a prescaler step.
  assign pre_en  = (state == COOKING) && door_closed && !clear;
  // Outside COOKING/PAUSED the count is meaningless, so holding it at zero
  // there guarantees every fresh start begins a full second.
  assign pre_clr = clear || (state == IDLE) || (state == DONE);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (tick)
  );

  always_comb begin
    state_nx = state;
    rem_nx   = remaining;
    s_nx     = 1'b0;
    r_nx     = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (clear) begin
          rem_nx = '0;
        end else if (load) begin
          rem_nx = time_in;
        end else if (start && door_closed && (remaining != '0)) begin
          state_nx = COOKING;
          s_nx     = 1'b1;
        end
      end
      COOKING: begin
        if (clear) begin
          state_nx = IDLE;
          rem_nx   = '0;
          r_nx     = 1'b1;
        end else if (!door_closed) begin
          state_nx = PAUSED;
          r_nx     = 1'b1;
        end else if (tick) begin
          // Saturating decrement: the last second ends the cook.
          if (remaining <= TIME_W'(1)) begin
            rem_nx   = '0;
            state_nx = DONE;
            r_nx     = 1'b1;
            done_nx  = 1'b1;
          end else begin
            rem_nx = remaining - 1'b1;
          end
        end
      end
      PAUSED: begin
        if (clear) begin
          state_nx = IDLE;
          rem_nx   = '0;
        end else if (start && door_closed) begin
          state_nx = COOKING;
          s_nx     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      S         <= 1'b0;
      R         <= 1'b1;
      mag_on    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      remaining <= rem_nx;
      S         <= s_nx;
      R         <= r_nx;
      mag_on    <= (state_nx == COOKING);
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_mag_controller.sv
// tb/tb_mag_controller.sv - self-checking bench for mag_controller
module tb_mag_controller;

  localparam int TD = 4;
  localparam int TW = 8;
  localparam int M_IDLE  = 0;
  localparam int M_COOK  = 1;
  localparam int M_PAUSE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [TW-1:0] time_in = '0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          door_closed = 1'b1;
  logic          S, R, mag_on, done;
  logic [TW-1:0] remaining;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: cook time is kept as a budget of magnetron-on clock cycles.
  int m_mode   = M_IDLE;
  int m_budget = 0;
  bit m_S, m_R, m_done;

  int s_pulses, r_pulses, done_pulses, closed_on;

  always #5 clk = ~clk;

  mag_controller #(.TICK_DIV(TD), .TIME_W(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .time_in     (time_in),
    .start       (start),
    .clear       (clear),
    .door_closed (door_closed),
    .S           (S),
    .R           (R),
    .mag_on      (mag_on),
    .remaining   (remaining),
    .done        (done)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("S", int'(S), int'(m_S));
    check("R", int'(R), int'(m_R));
    check("done", int'(done), int'(m_done));
    check("mag_on", int'(mag_on), (m_mode == M_COOK) ? 1 : 0);
    check("remaining", int'(remaining), (m_budget + TD - 1) / TD);
    check("s_and_r", int'(S && R), 0);
  endtask

  task automatic clear_counts();
    s_pulses = 0; r_pulses = 0; done_pulses = 0; closed_on = 0;
  endtask

  // Apply one cycle of inputs, advance the reference, then check everything.
  task automatic step(input bit ld, input int tin, input bit st, input bit clr, input bit dr);
    load = ld; time_in = TW'(tin); start = st; clear = clr; door_closed = dr;
    if (mag_on && dr) closed_on++;
    @(posedge clk);
    m_S = 0; m_R = 0; m_done = 0;
    case (m_mode)
      M_COOK: begin
        if (clr) begin
          m_mode = M_IDLE; m_budget = 0; m_R = 1;
        end else if (!dr) begin
          m_mode = M_PAUSE; m_R = 1;
        end else begin
          m_budget--;
          if (m_budget == 0) begin
            m_mode = M_IDLE; m_R = 1; m_done = 1;
          end
        end
      end
      M_PAUSE: begin
        if (clr) begin
          m_mode = M_IDLE; m_budget = 0;
        end else if (st && dr) begin
          m_mode = M_COOK; m_S = 1;
        end
      end
      default: begin
        if (clr) m_budget = 0;
        else if (ld) m_budget = tin * TD;
        else if (st && dr && m_budget != 0) begin
          m_mode = M_COOK; m_S = 1;
        end
      end
    endcase
    #1;
    check_all();
    if (S) s_pulses++;
    if (R) r_pulses++;
    if (done) done_pulses++;
  endtask

  task automatic idle_steps(input int n, input bit dr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, dr);
  endtask

  initial begin
    bit dr;
    // Reset state
    #12;
    m_S = 0; m_R = 1; m_done = 0;
    check_all();
    rst_n = 1'b1;
    step(0, 0, 0, 0, 1);
    check("r_after_release", int'(R), 0);

    // Basic cook: 3 s
    step(1, 3, 0, 0, 1);
    clear_counts();
    step(0, 0, 1, 0, 1);
    idle_steps(14, 1);
    check("basic_on_cycles", closed_on, 3 * TD);
    check("basic_s_pulses", s_pulses, 1);
    check("basic_r_pulses", r_pulses, 1);
    check("basic_done_pulses", done_pulses, 1);

    // Door pause: 5 s, door opens mid-second, start while open is ignored
    step(1, 5, 0, 0, 1);
    clear_counts();
    step(0, 0, 1, 0, 1);
    idle_steps(5, 1);
    step(0, 0, 0, 0, 0);
    check("pause_remaining", int'(remaining), 4);
    check("pause_r", int'(R), 1);
    step(0, 0, 1, 0, 0);
    step(1, 9, 0, 0, 0);
    check("pause_load_ignored", int'(remaining), 4);
    step(0, 0, 1, 0, 1);
    idle_steps(20, 1);
    check("pause_on_cycles", closed_on, 5 * TD);
    check("pause_s_pulses", s_pulses, 2);
    check("pause_done_pulses", done_pulses, 1);

    // Clear mid-cook
    step(1, 2, 0, 0, 1);
    clear_counts();
    step(0, 0, 1, 0, 1);
    idle_steps(2, 1);
    step(0, 0, 0, 1, 1);
    check("clear_remaining", int'(remaining), 0);
    check("clear_r", int'(R), 1);
    idle_steps(10, 1);
    check("clear_no_done", done_pulses, 0);

    // Illegal starts
    clear_counts();
    step(0, 0, 1, 0, 1);
    step(1, 5, 1, 0, 1);
    check("load_start_remaining", int'(remaining), 5);
    step(0, 0, 1, 0, 0);
    check("illegal_s_pulses", s_pulses, 0);

    // Reset mid-cook
    step(0, 0, 1, 0, 1);
    idle_steps(3, 1);
    rst_n = 1'b0;
    #2;
    m_mode = M_IDLE; m_budget = 0; m_S = 0; m_R = 1; m_done = 0;
    check("rst_R", int'(R), 1);
    check("rst_mag_on", int'(mag_on), 0);
    check_all();
    #2 rst_n = 1'b1;
    step(0, 0, 0, 0, 1);
    check("rst_release_R", int'(R), 0);

    // Randomised traffic against the reference
    dr = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 5) dr = !dr;
      step($urandom_range(0, 99) < 8, int'($urandom_range(0, 4)),
           $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 2, dr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mag_controller.md
# mag_controller

Cooking-cycle sequencer for the microwave's magnetron. It holds a countdown of cook time in seconds and walks an IDLE/COOKING/PAUSED/DONE state machine. It emits one-cycle set/reset pulses on `S`/`R` that drive the magnetron latch's `S`/`R` inputs directly. It sits between the user-input logic (keypad load, start, clear, door switch) and the latch, and is the only agent allowed to drive the latch.

## Interface
- `TICK_DIV`, default 100_000_000: clock cycles per one-second tick; minimum 2.
- `TIME_W`, default 12: width of the seconds countdown.
- `clk` input, 1 bit: single clock, all logic rising-edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `load` input, 1 bit: when high, `time_in` is written to the countdown.
- `time_in` input, `TIME_W` bits: cook time in seconds.
- `start` input, 1 bit: request to begin or resume cooking.
- `clear` input, 1 bit: abort and zero the countdown.
- `door_closed` input, 1 bit: 1 means the door is closed. The input is already synchronised.
- `S` output, 1 bit: latch set pulse that turns the magnetron on.
- `R` output, 1 bit: latch reset pulse that turns the magnetron off.
- `mag_on` output, 1 bit: high exactly while the state is COOKING.
- `remaining` output, `TIME_W` bits: current countdown value.
- `done` output, 1 bit: one-cycle pulse when the countdown expires.

## Operation
- States are IDLE, COOKING, PAUSED and DONE.
- **Reset values:**
  - state=IDLE, `remaining`=0, prescaler=0.
  - `S`=0, `R`=1, `mag_on`=0, `done`=0.
  - `R` stays 1 while `rst_n`=0 and drops on the first clock edge after release.
- **Outputs:**
  - All outputs are registered.
  - `S` and `R` are never high together.
  - Outside transition cycles both are 0, so the latch holds.
- **IDLE and DONE:**
  - `load` writes `remaining` <= `time_in`.
  - `start` && `door_closed` && `remaining`!=0 moves to COOKING, clears the prescaler and pulses `S`.
  - `start` is ignored in the same cycle as `load`. `load` wins.
  - `start` is ignored when `remaining`=0 or the door is open.
- **COOKING:**
  - Priority order: `clear` > door open > tick.
  - Prescaler counts 0..`TICK_DIV`-1. At `TICK_DIV`-1 it wraps to 0 and `remaining` decrements.
  - Tick with `remaining`=1: `remaining` goes to 0, move to DONE, pulse `R`, pulse `done`.
  - `door_closed`=0: move to PAUSED, pulse `R`. The prescaler and `remaining` freeze.
  - `clear`: move to IDLE, set `remaining` to 0, clear the prescaler, pulse `R`.
  - `load` and `start` are ignored.
- **PAUSED:**
  - `start` && `door_closed` moves to COOKING and pulses `S`. The prescaler resumes from its held value, so no time is lost or gained.
  - `clear` moves to IDLE, zeroes `remaining` and the prescaler, with no pulse because the magnetron is already off.
  - `clear` beats `start` in the same cycle.
  - `load` is ignored, so the held time is preserved.
- **DONE:** lasts exactly one cycle, then goes to IDLE unconditionally. Inputs in that cycle follow the IDLE rules.
- `clear` in IDLE zeroes `remaining`.

## Timing
- `start` sampled at edge k gives `S`=1 and `mag_on`=1 from edge k to edge k+1. `S` returns to 0 at k+1.
- Cook duration from the `S` edge to the `R` edge is exactly `time_in`×`TICK_DIV` cycles, provided there is no pause.
- Door opening sampled at edge k gives `R`=1 and `mag_on`=0 after edge k. Latency is one cycle.
- `done` and `R` assert on the same edge. `mag_on` falls on that edge.
- Asserting `rst_n` mid-cook forces `R`=1 and `mag_on`=0 immediately, without waiting for a clock.
- The `remaining` decrement and the `done` pulse never underflow. `remaining` saturates at 0.

## Structure
- Package `mag_pkg` holds:
  - the state enum `mag_state_t` (IDLE, COOKING, PAUSED, DONE);
  - default `TICK_DIV_DEF` and `TIME_W_DEF`.
- Sub-module `tick_prescaler`:
  - ports `clk`, `rst_n`, `en`, `clr`, output `tick`;
  - counter of width $clog2(`TICK_DIV`);
  - `tick` is high when the count equals `TICK_DIV`-1 and `en` is high.
- The top level holds the FSM, the countdown register and the pulse registers.

## Test plan
All scenarios use `TICK_DIV`=4.
- **Basic cook:** load 3, start with the door closed → `S` pulse one cycle; `mag_on` high 12 cycles; `remaining` goes 3→2→1→0 every 4 cycles; `R` and `done` pulse together; state returns to IDLE.
- **Door pause:** load 5, start, open the door after 6 cycles → `R` pulse, `remaining`=4, prescaler held at 1. Close the door and start → total `mag_on` cycles = 20.
- **Clear mid-cook:** load 2, start, clear at cycle 3 → `R` pulse, `remaining`=0, no `done` pulse.
- **Illegal starts:** start with `remaining`=0 → no `S`. Start with the door open → no `S`. Load and start in the same cycle → `remaining`=`time_in` and no `S`.
- **Reset mid-cook:** drop `rst_n` mid-cook → `R`=1 and `mag_on`=0 immediately. Release → `R` falls after the first edge.
- **Mutual exclusion:** throughout every scenario, assert `S`&&`R` is never true.
